// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline interlock controller:
//   - operand forwarding select encodings (FWD_*)
//   - multicycle sequencer state type
//   - default EX occupancy of a multicycle op
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  // Operand select encodings driven onto fwda/fwdb.
  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  // Multicycle sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_e;

  // EX occupancy of a mul/div in cycles (legal 2..15, fits the 4-bit counter).
  localparam int MC_LAT_DEFAULT = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle of the ID/EX/MEM status signals seen by the hazard controller and
// the interlock/forwarding controls it returns to the datapath.
//   master : datapath side (drives stage status, receives controls)
//   slave  : controller side (receives stage status, drives controls)
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int RN_W  = 5,
  parameter int CNT_W = 16
);

  // ID stage
  logic [RN_W-1:0]  drs;
  logic [RN_W-1:0]  drt;
  logic             drs_used;
  logic             drt_used;
  logic             dmc;
  logic             dbranch_taken;
  // EX stage
  logic [RN_W-1:0]  ern;
  logic             ewreg;
  logic             em2reg;
  // MEM stage
  logic [RN_W-1:0]  mrn;
  logic             mwreg;
  logic             mm2reg;
  // Controls back to the pipeline
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             wpcir;
  logic             de_bubble;
  logic             ex_hold;
  logic             em_bubble;
  logic             ifid_flush;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output drs, drt, drs_used, drt_used, dmc, dbranch_taken,
           ern, ewreg, em2reg, mrn, mwreg, mm2reg,
    input  fwda, fwdb, wpcir, de_bubble, ex_hold, em_bubble,
           ifid_flush, mc_busy, stall_cnt
  );

  modport slave (
    input  drs, drt, drs_used, drt_used, dmc, dbranch_taken,
           ern, ewreg, em2reg, mrn, mwreg, mm2reg,
    output fwda, fwdb, wpcir, de_bubble, ex_hold, em_bubble,
           ifid_flush, mc_busy, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// pipe_fwd_sel
// Combinational operand-forwarding select for one ID source register.
// Ports:
//   rn_i               : ID source register number
//   ern_i/ewreg_i/em2reg_i : EX destination, write enable, load flag
//   mrn_i/mwreg_i/mm2reg_i : MEM destination, write enable, load flag
//   fwd_o              : 2-bit select (FWD_* encodings)
// ---------------------------------------------------------------------------
module pipe_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RN_W = 5
) (
  input  logic [RN_W-1:0] rn_i,
  input  logic [RN_W-1:0] ern_i,
  input  logic            ewreg_i,
  input  logic            em2reg_i,
  input  logic [RN_W-1:0] mrn_i,
  input  logic            mwreg_i,
  input  logic            mm2reg_i,
  output logic [1:0]      fwd_o
);

  logic rnNonZero;
  logic exHit;
  logic memHit;

  assign rnNonZero = (rn_i != '0);
  assign exHit     = rnNonZero && ewreg_i && (ern_i == rn_i);
  assign memHit    = rnNonZero && mwreg_i && (mrn_i == rn_i);

  // The youngest producer wins: an EX ALU result beats anything in MEM.
  // A load still in EX cannot be forwarded, so it falls through to MEM
  // (the load-use interlock covers that case).
  always_comb begin
    fwd_o = FWD_RF;
    if (exHit && !em2reg_i) begin
      fwd_o = FWD_EXALU;
    end else if (memHit && !mm2reg_i) begin
      fwd_o = FWD_MEMALU;
    end else if (memHit && mm2reg_i) begin
      fwd_o = FWD_MEMLD;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline interlock and sequencing controller for the 5-stage pipeline:
// operand forwarding for ID, load-use stall, multicycle EX sequencing,
// IF/ID flush for taken branches and a saturating stall-cycle counter.
// Ports:
//   clock  : pipeline clock, rising edge
//   resetn : asynchronous, active-low reset
//   hz     : slave side of pipe_hazard_ctrl_if (stage status in, controls out)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DEFAULT,
  parameter int RN_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic               clock,
  input  logic               resetn,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam logic [3:0] MC_LAST = 4'(MC_LAT - 1);

  mc_state_e        state_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;
  logic             loadUse;
  logic             wpcirInt;

  // Forwarding selects for both ID source operands.
  pipe_fwd_sel #(.RN_W(RN_W)) u_fwd_rs (
    .rn_i     (hz.drs),
    .ern_i    (hz.ern),
    .ewreg_i  (hz.ewreg),
    .em2reg_i (hz.em2reg),
    .mrn_i    (hz.mrn),
    .mwreg_i  (hz.mwreg),
    .mm2reg_i (hz.mm2reg),
    .fwd_o    (hz.fwda)
  );

  pipe_fwd_sel #(.RN_W(RN_W)) u_fwd_rt (
    .rn_i     (hz.drt),
    .ern_i    (hz.ern),
    .ewreg_i  (hz.ewreg),
    .em2reg_i (hz.em2reg),
    .mrn_i    (hz.mrn),
    .mwreg_i  (hz.mwreg),
    .mm2reg_i (hz.mm2reg),
    .fwd_o    (hz.fwdb)
  );

  // A load in EX whose destination is read by the ID instruction cannot be
  // forwarded in time; hold ID for one cycle and bubble the slot into EX.
  assign loadUse = hz.ewreg && hz.em2reg && (hz.ern != '0) &&
                   (((hz.ern == hz.drs) && hz.drs_used) ||
                    ((hz.ern == hz.drt) && hz.drt_used));

  // While the sequencer is busy, ID is frozen, so load-use and branch
  // decisions are suppressed and re-evaluated once it returns to IDLE.
  assign wpcirInt      = !(busy_q || loadUse);
  assign hz.wpcir      = wpcirInt;
  assign hz.de_bubble  = loadUse && !busy_q;
  assign hz.ifid_flush = hz.dbranch_taken && !loadUse && !busy_q;
  assign hz.ex_hold    = busy_q;
  assign hz.em_bubble  = busy_q;
  assign hz.mc_busy    = busy_q;

  // Multicycle sequencer: a mul/div accepted in IDLE enters EX on that edge,
  // then BUSY holds the front of the pipe for MC_LAT-1 further cycles while
  // bubbles flow into MEM. busy_q is the registered copy of "in BUSY" that
  // drives the hold/bubble outputs, so reset drops them immediately.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hz.dmc && !loadUse) begin
            state_q <= ST_BUSY;
            cnt_q   <= MC_LAST;
            busy_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall statistics: count every edge on which the front end is held,
  // sticking at all-ones instead of wrapping.
  always_comb begin
    stall_d = stall_q;
    if (!wpcirInt && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign hz.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized stimulus compared against a behavioural model that tracks the
// remaining busy cycles and the expected stall count as plain integers.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int MC_LAT = 4;
  localparam int RN_W   = 5;
  localparam int CNT_W  = 16;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.RN_W(RN_W), .CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .RN_W(RN_W), .CNT_W(CNT_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .hz     (hz.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: busy cycles still to come, expected stall count.
  int busyLeft   = 0;
  int stallModel = 0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Forwarding choice for one source register, straight from the rules.
  function automatic logic [1:0] fwdModel(input int rn);
    if (rn != 0 && hz.ewreg && !hz.em2reg && int'(hz.ern) == rn) return 2'd1;
    if (rn != 0 && hz.mwreg && !hz.mm2reg && int'(hz.mrn) == rn) return 2'd2;
    if (rn != 0 && hz.mwreg && hz.mm2reg && int'(hz.mrn) == rn) return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit luModel();
    return hz.ewreg && hz.em2reg && hz.ern != 0 &&
           ((hz.ern == hz.drs && hz.drs_used) || (hz.ern == hz.drt && hz.drt_used));
  endfunction

  task automatic setIdle();
    hz.drs = '0; hz.drt = '0; hz.drs_used = 1'b0; hz.drt_used = 1'b0;
    hz.dmc = 1'b0; hz.dbranch_taken = 1'b0;
    hz.ern = '0; hz.ewreg = 1'b0; hz.em2reg = 1'b0;
    hz.mrn = '0; hz.mwreg = 1'b0; hz.mm2reg = 1'b0;
  endtask

  // Random ID/EX/MEM status; small register range to provoke hazards.
  task automatic applyStimulus();
    hz.drs           = 5'($urandom_range(0, 3));
    hz.drt           = 5'($urandom_range(0, 3));
    hz.drs_used      = 1'($urandom_range(0, 1));
    hz.drt_used      = 1'($urandom_range(0, 1));
    hz.dmc           = ($urandom_range(0, 7) == 0);
    hz.dbranch_taken = ($urandom_range(0, 3) == 0);
    hz.ern           = 5'($urandom_range(0, 3));
    hz.ewreg         = 1'($urandom_range(0, 1));
    hz.em2reg        = 1'($urandom_range(0, 1));
    hz.mrn           = 5'($urandom_range(0, 3));
    hz.mwreg         = 1'($urandom_range(0, 1));
    hz.mm2reg        = 1'($urandom_range(0, 1));
  endtask

  // Advance the model by one clock edge given this cycle's decisions.
  task automatic modelEdge(input bit expWpcir, input bit accept);
    if (busyLeft > 0) busyLeft--;
    else if (accept) busyLeft = MC_LAT - 1;
    if (!expWpcir && stallModel < SAT) stallModel++;
  endtask

  // Called at a negedge with inputs applied: check every output against the
  // model, cross the posedge, update the model and return at the next negedge.
  task automatic runCycle(input string tag, input bit doCheck);
    bit busy, lu, expWpcir;
    #1;
    busy     = (busyLeft > 0);
    lu       = luModel();
    expWpcir = !(busy || lu);
    if (doCheck) begin
      checkOutput({tag, ".fwda"},       32'(hz.fwda),       32'(fwdModel(int'(hz.drs))));
      checkOutput({tag, ".fwdb"},       32'(hz.fwdb),       32'(fwdModel(int'(hz.drt))));
      checkOutput({tag, ".wpcir"},      32'(hz.wpcir),      32'(expWpcir));
      checkOutput({tag, ".de_bubble"},  32'(hz.de_bubble),  32'(lu && !busy));
      checkOutput({tag, ".ex_hold"},    32'(hz.ex_hold),    32'(busy));
      checkOutput({tag, ".em_bubble"},  32'(hz.em_bubble),  32'(busy));
      checkOutput({tag, ".ifid_flush"}, 32'(hz.ifid_flush), 32'(hz.dbranch_taken && !lu && !busy));
      checkOutput({tag, ".mc_busy"},    32'(hz.mc_busy),    32'(busy));
      checkOutput({tag, ".stall_cnt"},  32'(hz.stall_cnt),  32'(stallModel));
    end
    @(posedge clock);
    modelEdge(expWpcir, !busy && hz.dmc && !lu);
    @(negedge clock);
  endtask

  task automatic doReset();
    @(negedge clock);
    resetn = 1'b0;
    setIdle();
    busyLeft   = 0;
    stallModel = 0;
    #2;
    resetn = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    $display("[TB] start");
    setIdle();
    #3;
    checkOutput("reset.mc_busy",   32'(hz.mc_busy),   32'd0);
    checkOutput("reset.ex_hold",   32'(hz.ex_hold),   32'd0);
    checkOutput("reset.stall_cnt", 32'(hz.stall_cnt), 32'd0);
    checkOutput("reset.wpcir",     32'(hz.wpcir),     32'd1);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Forwarding priority: EX ALU, then MEM ALU, then MEM load, r0 never.
    hz.ewreg = 1'b1; hz.ern = 5'd5; hz.mwreg = 1'b1; hz.mrn = 5'd5; hz.drs = 5'd5;
    #1 checkOutput("fwd.ex", 32'(hz.fwda), 32'(FWD_EXALU));
    hz.ewreg = 1'b0;
    #1 checkOutput("fwd.memalu", 32'(hz.fwda), 32'(FWD_MEMALU));
    hz.mm2reg = 1'b1;
    #1 checkOutput("fwd.memld", 32'(hz.fwda), 32'(FWD_MEMLD));
    hz.ewreg = 1'b1; hz.ern = 5'd0; hz.mrn = 5'd0; hz.drs = 5'd0;
    #1 checkOutput("fwd.r0", 32'(hz.fwda), 32'(FWD_RF));
    doReset();

    // Load followed by a dependent instruction: one-cycle stall then forward.
    hz.ewreg = 1'b1; hz.em2reg = 1'b1; hz.ern = 5'd8; hz.drt = 5'd8; hz.drt_used = 1'b1;
    #1;
    checkOutput("lu.wpcir",     32'(hz.wpcir),     32'd0);
    checkOutput("lu.de_bubble", 32'(hz.de_bubble), 32'd1);
    runCycle("lu.c0", 1'b1);
    hz.ewreg = 1'b0; hz.em2reg = 1'b0; hz.ern = '0;
    hz.mwreg = 1'b1; hz.mm2reg = 1'b1; hz.mrn = 5'd8;
    #1;
    checkOutput("lu.stall_cnt", 32'(hz.stall_cnt), 32'd1);
    checkOutput("lu.fwdb",      32'(hz.fwdb),      32'(FWD_MEMLD));
    checkOutput("lu.wpcir_rel", 32'(hz.wpcir),     32'd1);
    doReset();

    // Multicycle op: exactly MC_LAT-1 busy cycles, then back to normal flow.
    hz.dmc = 1'b1;
    runCycle("mc.accept", 1'b1);
    hz.dmc = 1'b0;
    for (int i = 0; i < MC_LAT - 1; i++) begin
      #1;
      checkOutput("mc.busy",      32'(hz.mc_busy),   32'd1);
      checkOutput("mc.ex_hold",   32'(hz.ex_hold),   32'd1);
      checkOutput("mc.em_bubble", 32'(hz.em_bubble), 32'd1);
      checkOutput("mc.wpcir",     32'(hz.wpcir),     32'd0);
      runCycle("mc.run", 1'b1);
    end
    #1;
    checkOutput("mc.idle",      32'(hz.mc_busy),   32'd0);
    checkOutput("mc.stall_cnt", 32'(hz.stall_cnt), 32'(MC_LAT - 1));
    doReset();

    // Branch coincident with a load-use stall is deferred one cycle.
    hz.dbranch_taken = 1'b1;
    hz.ewreg = 1'b1; hz.em2reg = 1'b1; hz.ern = 5'd3; hz.drs = 5'd3; hz.drs_used = 1'b1;
    #1 checkOutput("br.lu_flush", 32'(hz.ifid_flush), 32'd0);
    runCycle("br.c0", 1'b1);
    hz.ewreg = 1'b0; hz.em2reg = 1'b0;
    #1;
    checkOutput("br.flush", 32'(hz.ifid_flush), 32'd1);
    checkOutput("br.wpcir", 32'(hz.wpcir),      32'd1);
    doReset();

    // Asynchronous reset in the second BUSY cycle.
    hz.dmc = 1'b1;
    runCycle("rst.accept", 1'b1);
    hz.dmc = 1'b0;
    runCycle("rst.busy1", 1'b1);
    #2;
    resetn = 1'b0;
    busyLeft = 0; stallModel = 0;
    #1;
    checkOutput("rst.mc_busy",   32'(hz.mc_busy),   32'd0);
    checkOutput("rst.ex_hold",   32'(hz.ex_hold),   32'd0);
    checkOutput("rst.em_bubble", 32'(hz.em_bubble), 32'd0);
    checkOutput("rst.stall_cnt", 32'(hz.stall_cnt), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    runCycle("rst.after", 1'b1);
    runCycle("rst.after2", 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus();
      runCycle("rand", 1'b1);
    end
    doReset();

    // Saturation of the stall counter via a permanent load-use hazard.
    hz.ewreg = 1'b1; hz.em2reg = 1'b1; hz.ern = 5'd9; hz.drs = 5'd9; hz.drs_used = 1'b1;
    for (int i = 0; i < SAT; i++) begin
      runCycle("sat", 1'b0);
    end
    #1 checkOutput("sat.reach", 32'(hz.stall_cnt), 32'(SAT));
    for (int i = 0; i < 5; i++) begin
      runCycle("sat.hold", 1'b0);
    end
    #1;
    checkOutput("sat.stay",  32'(hz.stall_cnt), 32'h0000FFFF);
    checkOutput("sat.model", 32'(hz.stall_cnt), 32'(stallModel));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline interlock and sequencing controller for the 5-stage pipeline. It resolves operand forwarding for the ID stage and detects load-use hazards. It sequences multicycle EX operations by freezing IF/ID/EX and injecting bubbles into EX/MEM, and it generates the IF/ID flush for taken branches. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MC_LAT, 4, EX occupancy in cycles of a multicycle op (mul/div); legal range 2..15
RN_W, 5, register-number width
CNT_W, 16, width of the stall statistics counter

Ports:
clock  in  1  pipeline clock, all state on rising edge
resetn  in  1  asynchronous, active-low reset
drs  in  RN_W  rs field of instruction in ID
drt  in  RN_W  rt field of instruction in ID
drs_used  in  1  ID instruction reads rs
drt_used  in  1  ID instruction reads rt
dmc  in  1  ID instruction is a multicycle EX op
dbranch_taken  in  1  branch/jump resolved taken in ID
ern  in  RN_W  EX-stage destination register
ewreg  in  1  EX-stage writes register
em2reg  in  1  EX-stage is a load
mrn  in  RN_W  MEM-stage destination register
mwreg  in  1  MEM-stage writes register
mm2reg  in  1  MEM-stage is a load
fwda  out  2  rs operand select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data
fwdb  out  2  rt operand select, same encoding
wpcir  out  1  PC and IF/ID write enable (0 = hold)
de_bubble  out  1  zero control bits (wreg, m2reg, wmem, jal) entering ID/EX
ex_hold  out  1  freeze ID/EX register and EX stage
em_bubble  out  1  zero control bits entering EX/MEM
ifid_flush  out  1  replace IF/ID contents with nop
mc_busy  out  1  multicycle sequencer in BUSY
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Forwarding (combinational, rs shown; rt identical): a register number of 0 never matches.
  - ewreg & ~em2reg & ern==drs -> 01.
  - Else mwreg & ~mm2reg & mrn==drs -> 10.
  - Else mwreg & mm2reg & mrn==drs -> 11.
  - Else 00. EX has priority over MEM.
- Load-use stall: lu = ewreg & em2reg & ern!=0 & ((ern==drs & drs_used) | (ern==drt & drt_used)). lu -> wpcir=0, de_bubble=1 for that cycle only.
- Multicycle FSM: states IDLE and BUSY, plus a 4-bit down-counter cnt.
  - IDLE: dmc & ~lu accepts the op. On that edge the op enters EX, cnt<=MC_LAT-1, state<=BUSY.
  - BUSY: ex_hold=1, wpcir=0, em_bubble=1, de_bubble=0, mc_busy=1. Each edge cnt<=cnt-1. When cnt==1 at an edge, state<=IDLE.
  - BUSY therefore lasts exactly MC_LAT-1 cycles. The op result enters EX/MEM MC_LAT edges after acceptance.
  - lu, ifid_flush and dmc are all ignored while BUSY. ID is frozen, so they are re-evaluated after BUSY ends.
- Branch flush: ifid_flush = dbranch_taken & ~lu & ~mc_busy. While stalled, the branch is re-evaluated the next cycle.
- Simultaneous events:
  - lu with dmc: lu wins and dmc is not accepted that cycle.
  - dbranch_taken with dmc (decoder never issues both): both take effect.
- Default, when no stall, flush or busy: wpcir=1, and de_bubble, ex_hold, em_bubble, ifid_flush all 0.
- stall_cnt increments on every edge where wpcir==0 and saturates at all-ones (no wrap).
- Reset (asynchronous, any time, including mid-BUSY): state=IDLE, cnt=0, stall_cnt=0, mc_busy=0. Registered-state-driven outputs are deasserted immediately: ex_hold=0, em_bubble=0. The pipeline resumes with wpcir=1 unless lu is asserted combinationally.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_EXALU=2'b01, FWD_MEMALU=2'b10, FWD_MEMLD=2'b11.
  - State enum ST_IDLE/ST_BUSY.
  - MC_LAT default constant.
- Sub-module pipe_fwd_sel, instantiated twice (rs, rt). It is purely combinational: reg number plus EX/MEM info in, 2-bit select out.
- FSM, hazard logic and counter stay in the top.

Test Plan:
- ewreg=1,em2reg=0,ern=5, mwreg=1,mrn=5,drs=5 -> fwda=01. Then set ewreg=0 -> fwda=10. Then set mm2reg=1 -> fwda=11. drs=0 with all of the above -> fwda=00.
- Load then dependent add: ewreg=1,em2reg=1,ern=8,drt=8,drt_used=1 -> one cycle wpcir=0,de_bubble=1,stall_cnt 0->1. Next cycle (load moved to MEM) -> fwdb=11, wpcir=1.
- dmc=1 with MC_LAT=4 -> after accept edge: mc_busy=1, ex_hold=1, em_bubble=1, wpcir=0 for exactly 3 cycles, then IDLE, stall_cnt=3.
- dbranch_taken=1 coincident with lu -> ifid_flush=0 that cycle. Next cycle (lu cleared) -> ifid_flush=1, wpcir=1.
- Assert resetn=0 in second BUSY cycle -> mc_busy, ex_hold, em_bubble drop asynchronously, stall_cnt=0. After release, state IDLE and wpcir=1.
- Force 65535 stall cycles via repeated lu -> stall_cnt=16'hFFFF and remains so on further stalls.
